// File: rtl/cpu_lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, fault codes,
// the control FSM state encoding and the request legality checks.
package cpu_lsu_pkg;

  // Access size codes as issued by the pipeline (bit 2 = unsigned load).
  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  // Completion status reported with every response.
  localparam logic [1:0] FAULT_OK         = 2'b00;
  localparam logic [1:0] FAULT_MISALIGNED = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL    = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT    = 2'b11;

  // Control FSM states. IDLE must stay at encoding 0 so the reset image of
  // every register in the unit is all zeros.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_RDATA = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Unused size encodings are illegal, and unsigned sizes only make sense
  // for loads, so a store carrying BU/HU is rejected as well.
  function automatic logic size_is_illegal(input logic [2:0] size,
                                           input logic       is_write);
    logic illegal;
    case (size)
      SIZE_B, SIZE_H, SIZE_W: illegal = 1'b0;
      SIZE_BU, SIZE_HU:       illegal = is_write;
      default:                illegal = 1'b1;
    endcase
    return illegal;
  endfunction

  // Halfwords need an even address, words a word-aligned address.
  function automatic logic addr_is_misaligned(input logic [2:0] size,
                                              input logic [1:0] offset);
    logic misaligned;
    case (size)
      SIZE_H, SIZE_HU: misaligned = offset[0];
      SIZE_W:          misaligned = (offset != 2'b00);
      default:         misaligned = 1'b0;
    endcase
    return misaligned;
  endfunction

  // Illegal size takes priority over misalignment.
  function automatic logic [1:0] request_fault(input logic [2:0] size,
                                               input logic       is_write,
                                               input logic [1:0] offset);
    logic [1:0] fault;
    if (size_is_illegal(size, is_write)) begin
      fault = FAULT_ILLEGAL;
    end else if (addr_is_misaligned(size, offset)) begin
      fault = FAULT_MISALIGNED;
    end else begin
      fault = FAULT_OK;
    end
    return fault;
  endfunction

endpackage

// File: rtl/cpu_lsu_lane.sv
// Byte-lane steering for a word-wide data bus: store byte strobes, store
// data replicated across all lanes, and load data shifted down to bit 0.
// Purely combinational; sign/zero extension is left to the downstream stage.
module cpu_lsu_lane
  import cpu_lsu_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  strb_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_o
);

  // Strobe and replicated store data selected by access size.
  always_comb begin
    strb_o      = 4'b0000;
    wdata_rep_o = wdata_i;
    case (size_i)
      SIZE_B, SIZE_BU: begin
        strb_o      = 4'b0001 << offset_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
      end
      SIZE_H, SIZE_HU: begin
        strb_o      = 4'b0011 << offset_i;
        wdata_rep_o = {2{wdata_i[15:0]}};
      end
      SIZE_W: begin
        strb_o      = 4'b1111;
        wdata_rep_o = wdata_i;
      end
      default: begin
        strb_o      = 4'b0000;
        wdata_rep_o = wdata_i;
      end
    endcase
  end

  // Load data: drop the bytes below the access offset, zero-fill the top.
  assign rdata_o = rdata_i >> {offset_i, 3'b000};

endmodule

// File: rtl/cpu_lsu.sv
// Load/store unit between the memory pipeline stage and the data bus.
// One request in flight at a time: accept, check, run one word-aligned bus
// transaction, then pulse a response.
//
// Handshakes: a transfer on a valid/ready pair happens in a cycle where both
// are high at the rising edge. The request side (req_valid/req_ready) and the
// bus address side (mem_valid/mem_ready) follow this rule; once mem_valid is
// raised, address, write, strobes and data are held until mem_ready is seen.
// mem_rvalid and resp_valid are single-cycle pulses with no backpressure.
module cpu_lsu
  import cpu_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        rst,
  // pipeline request
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  // pipeline response
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [2:0]  resp_size,
  output logic [1:0]  resp_fault,
  // data-memory bus
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  // debug visibility of the control FSM
  output state_t      dbg_state
);

  // Timeout fires on the cycle whose increment would bring the counter to
  // TIMEOUT_CYCLES, so mem_valid is high for exactly TIMEOUT_CYCLES cycles.
  // The compare is >= so the limit still applies after a late handshake has
  // already carried the counter into RDATA past the limit.
  localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic                 write_q, write_d;
  logic [2:0]           size_q,  size_d;
  logic [31:0]          addr_q,  addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [1:0]           fault_q, fault_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;

  logic       accept;
  logic [1:0] req_fault;
  logic       timeout_hit;
  logic [3:0] lane_strb;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  assign accept      = req_valid && (state_q == ST_IDLE);
  assign req_fault   = request_fault(req_size, req_write, req_addr[1:0]);
  assign timeout_hit = TO_EN && (cnt_q >= TO_LAST);

  cpu_lsu_lane u_lane (
    .size_i      (size_q),
    .offset_i    (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .rdata_i     (mem_rdata),
    .strb_o      (lane_strb),
    .wdata_rep_o (lane_wdata),
    .rdata_o     (lane_rdata)
  );

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A bus handshake or read return in the same cycle as
  // the timeout takes precedence over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (req_fault != FAULT_OK) ? ST_RESP : ST_BUS;
        end
      end
      ST_BUS: begin
        if (mem_ready) begin
          state_d = write_q ? ST_RESP : ST_RDATA;
        end else if (timeout_hit) begin
          state_d = ST_RESP;
        end
      end
      ST_RDATA: begin
        if (mem_rvalid || timeout_hit) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request, status and counter next values; captured on acceptance and
  // updated while the bus access runs.
  always_comb begin
    write_d = write_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d = req_write;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          fault_d = req_fault;
          rdata_d = 32'h0;
          cnt_d   = '0;
        end
      end
      ST_BUS: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        if (!mem_ready && timeout_hit) begin
          fault_d = FAULT_TIMEOUT;
        end
      end
      ST_RDATA: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        if (mem_rvalid) begin
          rdata_d = lane_rdata;
        end else if (timeout_hit) begin
          fault_d = FAULT_TIMEOUT;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Datapath registers; cleared on reset so every output idles at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_q <= 1'b0;
      size_q  <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      fault_q <= FAULT_OK;
      rdata_q <= 32'h0;
      cnt_q   <= '0;
    end else begin
      write_q <= write_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from the current state; bus controls only in BUS.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    busy       = (state_q != ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    mem_valid  = (state_q == ST_BUS);
    mem_write  = (state_q == ST_BUS) && write_q;
    mem_wstrb  = ((state_q == ST_BUS) && write_q) ? lane_strb : 4'b0000;
  end

  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = lane_wdata;
  assign resp_rdata = rdata_q;
  assign resp_size  = size_q;
  assign resp_fault = fault_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cpu_lsu.sv
// Directed bench for cpu_lsu: a vector table of single requests with a
// scripted bus responder, plus hand-written reset-abort sequences.
module tb_cpu_lsu;
  import cpu_lsu_pkg::*;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [2:0]  resp_size;
  logic [1:0]  resp_fault;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  state_t      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // expected response {fault, size, rdata}
  logic [36:0] exp_q[$];

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    int          ready_dly;
    logic [1:0]  e_fault;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    int          e_lat;
    int          e_bus;
  } vec_t;

  vec_t vq[$];

  cpu_lsu #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_size  (resp_size),
    .resp_fault (resp_fault),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  // clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_ctrl"},
          {50'h0, req_ready, busy, resp_valid, resp_size, resp_fault, mem_valid, mem_write, mem_wstrb},
          {50'h0, 1'b1, 13'h0});
    check({nm, "_rdata_addr"}, {resp_rdata, mem_addr}, 64'h0);
    check({nm, "_wdata"}, {32'h0, mem_wdata}, 64'h0);
  endtask

  // scoreboard: every response pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got fault %0d rdata 0x%0h with nothing expected",
                 resp_fault, resp_rdata);
      end else begin
        check("resp_fields", {27'h0, resp_fault, resp_size, resp_rdata}, {27'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic add_vec(input string nm, input logic wr, input logic [2:0] sz,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] brd,
                         input int dly, input logic [1:0] ef, input logic [3:0] es,
                         input logic [31:0] ew, input logic [31:0] er, input int el, input int eb);
    vec_t v;
    v.name = nm; v.wr = wr; v.sz = sz; v.addr = ad; v.wdata = wd; v.bus_rdata = brd;
    v.ready_dly = dly; v.e_fault = ef; v.e_strb = es; v.e_wdata = ew; v.e_rdata = er;
    v.e_lat = el; v.e_bus = eb;
    vq.push_back(v);
  endtask

  // driver + bus responder for one request; mem_ready rises after ready_dly
  // cycles of mem_valid, read data returns the cycle after the handshake
  task automatic run_vec(input vec_t v);
    int cyc;
    int bus_cyc;
    bit hs;
    bit got;
    bit bus_ok;
    bit hold_ok;
    @(negedge clk);
    check({v.name, "_req_ready"}, req_ready, 1);
    exp_q.push_back({v.e_fault, v.sz, v.e_rdata});
    req_valid = 1'b1; req_write = v.wr; req_size = v.sz;
    req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_size = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    cyc = 1; bus_cyc = 0; hs = 0; got = 0; bus_ok = 1; hold_ok = 1;
    while (!got && cyc <= 20) begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h5A5A_5A5A;
      if (hs && !v.wr) begin
        mem_rvalid = 1'b1;
        mem_rdata  = v.bus_rdata;
      end
      hs = 0;
      mem_ready = 1'b0;
      if (mem_valid) begin
        if (mem_addr !== (v.addr & ~32'h3) || mem_write !== v.wr ||
            mem_wstrb !== v.e_strb || (v.wr && mem_wdata !== v.e_wdata)) bus_ok = 0;
        if (bus_cyc >= v.ready_dly) begin
          mem_ready = 1'b1;
          hs = 1;
        end
        bus_cyc++;
      end
      if (req_ready !== 1'b0 || busy !== 1'b1) hold_ok = 0;
      if (resp_valid === 1'b1) begin
        got = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    check({v.name, "_latency"}, got ? cyc : -1, v.e_lat);
    check({v.name, "_bus_cycles"}, bus_cyc, v.e_bus);
    check({v.name, "_bus_fields"}, bus_ok, 1);
    check({v.name, "_stall"}, hold_ok, 1);
    if (!got) exp_q.delete();
    @(negedge clk);
    check({v.name, "_after"}, {req_ready, busy, resp_valid, mem_valid}, 4'b1000);
  endtask

  initial begin
    bit quiet;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'h0;

    //      name              wr sz      addr          wdata         bus rdata     dly fault strb     e_wdata       e_rdata       lat bus
    add_vec("sb_1003",        1, SIZE_B,  32'h0000_1003, 32'h0000_00AB, 32'h0,        0, 2'b00, 4'b1000, 32'hABAB_ABAB, 32'h0,        2, 1);
    add_vec("lhu_2002",       0, SIZE_HU, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 2'b00, 4'b0000, 32'h0,        32'h0000_BEEF, 3, 1);
    add_vec("lw_2001",        0, SIZE_W,  32'h0000_2001, 32'h0,        32'h0,        0, 2'b01, 4'b0000, 32'h0,        32'h0,        1, 0);
    add_vec("st_hu_2000",     1, SIZE_HU, 32'h0000_2000, 32'h0000_1234, 32'h0,        0, 2'b10, 4'b0000, 32'h0,        32'h0,        1, 0);
    add_vec("sw_3000_wait3",  1, SIZE_W,  32'h0000_3000, 32'hDEAD_BEEF, 32'h0,        3, 2'b00, 4'b1111, 32'hDEAD_BEEF, 32'h0,        5, 4);
    add_vec("sh_1002_wait1",  1, SIZE_H,  32'h0000_1002, 32'h1234_CDEF, 32'h0,        1, 2'b00, 4'b1100, 32'hCDEF_CDEF, 32'h0,        3, 2);
    add_vec("sb_1001",        1, SIZE_B,  32'h0000_1001, 32'hFFFF_FF5A, 32'h0,        0, 2'b00, 4'b0010, 32'h5A5A_5A5A, 32'h0,        2, 1);
    add_vec("lb_4001",        0, SIZE_B,  32'h0000_4001, 32'h0,        32'h1122_3344, 0, 2'b00, 4'b0000, 32'h0,        32'h0011_2233, 3, 1);
    add_vec("lw_4000",        0, SIZE_W,  32'h0000_4000, 32'h0,        32'hCAFE_F00D, 0, 2'b00, 4'b0000, 32'h0,        32'hCAFE_F00D, 3, 1);
    add_vec("ld_size011",     0, 3'b011,  32'h0000_4000, 32'h0,        32'h0,        0, 2'b10, 4'b0000, 32'h0,        32'h0,        1, 0);
    add_vec("st_hu_4003",     1, SIZE_HU, 32'h0000_4003, 32'h0,        32'h0,        0, 2'b10, 4'b0000, 32'h0,        32'h0,        1, 0);
    add_vec("lh_4001",        0, SIZE_H,  32'h0000_4001, 32'h0,        32'h0,        0, 2'b01, 4'b0000, 32'h0,        32'h0,        1, 0);
    add_vec("sw_3002",        1, SIZE_W,  32'h0000_3002, 32'h1111_2222, 32'h0,        0, 2'b01, 4'b0000, 32'h0,        32'h0,        1, 0);
    add_vec("lbu_4003",       0, SIZE_BU, 32'h0000_4003, 32'h0,        32'hA500_0000, 0, 2'b00, 4'b0000, 32'h0,        32'h0000_00A5, 3, 1);
    add_vec("lw_5000_tmo",    0, SIZE_W,  32'h0000_5000, 32'h0,        32'h0,       99, 2'b11, 4'b0000, 32'h0,        32'h0,        5, 4);
    add_vec("sw_7000_tmo",    1, SIZE_W,  32'h0000_7000, 32'h0102_0304, 32'h0,       99, 2'b11, 4'b1111, 32'h0102_0304, 32'h0,        5, 4);
    add_vec("lw_6000_wait3",  0, SIZE_W,  32'h0000_6000, 32'h0,        32'h0BAD_CAFE, 3, 2'b00, 4'b0000, 32'h0,        32'h0BAD_CAFE, 6, 4);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    for (int i = 0; i < vq.size(); i++) begin
      run_vec(vq[i]);
    end

    // reset while the bus request is pending: mem_valid drops next cycle
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_W;
    req_addr = 32'h0000_8000; req_wdata = 32'h55AA_55AA;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstbus_mem_valid", mem_valid, 1);
    mem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstbus_drop", mem_valid, 0);
    check_reset_outputs("rstbus");
    rst = 1'b0;

    // reset while waiting for read data, then a stale read return
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = SIZE_W;
    req_addr = 32'h0000_9000; req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstrd_mem_valid", mem_valid, 1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("rstrd_state", dbg_state, ST_RDATA);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rstrd");
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    quiet = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (resp_valid !== 1'b0 || mem_valid !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    check("rstrd_quiet", quiet, 1);
    check("rstrd_rdata", resp_rdata, 32'h0);

    // the unit works normally after the abort
    begin
      vec_t v;
      v.name = "lh_9002_after_rst"; v.wr = 1'b0; v.sz = SIZE_H; v.addr = 32'h0000_9002;
      v.wdata = 32'h0; v.bus_rdata = 32'h8765_4321; v.ready_dly = 0; v.e_fault = 2'b00;
      v.e_strb = 4'b0000; v.e_wdata = 32'h0; v.e_rdata = 32'h0000_8765; v.e_lat = 3; v.e_bus = 1;
      run_vec(v);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
